// File: rtl/pll_clken_seq.sv
// PLL lock sequencer with per-channel fractional clock-enable generators.
// Optional lock-loss counter is built when PLL_CLKEN_LOSSCNT_EN is defined.
module pll_clken_seq #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned ACC_W       = 16,
    parameter int unsigned LOCK_FILTER = 255,
    parameter int unsigned RST_STRETCH = 16
) (
    input  logic                    refclk,
    input  logic                    rst_n,
    input  logic                    locked_i,
    input  logic [NUM_CH*ACC_W-1:0] inc_i,
    input  logic [NUM_CH-1:0]       en_i,
    output logic [NUM_CH-1:0]       clken_o,
    output logic                    sys_rst_o,
    output logic                    ready_o,
    output logic                    lock_lost_o,
    output logic [7:0]              lock_loss_cnt_o
);

    typedef enum logic [1:0] {StWaitLock, StFilter, StStretch, StRun} state_e;

    localparam logic [15:0] FilterLast  = 16'(LOCK_FILTER - 1);
    localparam logic [15:0] StretchLast = 16'(RST_STRETCH - 1);

    state_e                         state_q, state_d;
    logic [15:0]                    cnt_q, cnt_d;
    logic                           lk_meta_q, lk_q;
    logic                           sys_rst_q;
    logic                           lost_q, lost_d;
    logic [NUM_CH-1:0][ACC_W-1:0]   acc_q, acc_d;
    logic [NUM_CH-1:0]              clken_q, clken_d;
    logic [ACC_W:0]                 sum [NUM_CH];
    logic                           run_add;

    // Two-flop synchroniser for the asynchronous lock indication.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lk_meta_q <= 1'b0;
            lk_q      <= 1'b0;
        end else begin
            lk_meta_q <= locked_i;
            lk_q      <= lk_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lost_d  = 1'b0;
        case (state_q)
            StWaitLock: begin
                if (lk_q) begin
                    state_d = StFilter;
                    cnt_d   = '0;
                end
            end
            StFilter: begin
                if (!lk_q) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_q == FilterLast) begin
                    state_d = StStretch;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StStretch: begin
                if (!lk_q) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_q == StretchLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StRun: begin
                if (!lk_q) begin
                    state_d = StWaitLock;
                    lost_d  = 1'b1;
                end
            end
            default: state_d = StWaitLock;
        endcase
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StWaitLock;
            cnt_q     <= '0;
            sys_rst_q <= 1'b1;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sys_rst_q <= (state_d != StRun);
            lost_q    <= lost_d;
        end
    end

    // Accumulators only advance while running and still locked, so a lock
    // drop clears them in the same cycle it is observed.
    assign run_add = (state_q == StRun) && lk_q;

    always_comb begin
        for (int k = 0; k < int'(NUM_CH); k++) begin
            sum[k] = {1'b0, acc_q[k]} + {1'b0, inc_i[k*ACC_W +: ACC_W]};
            if (run_add && en_i[k]) begin
                acc_d[k]   = sum[k][ACC_W-1:0];
                clken_d[k] = sum[k][ACC_W];
            end else begin
                acc_d[k]   = '0;
                clken_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            clken_q <= '0;
        end else begin
            acc_q   <= acc_d;
            clken_q <= clken_d;
        end
    end

`ifdef PLL_CLKEN_LOSSCNT_EN
    logic [7:0] loss_cnt_q;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt_q <= '0;
        end else if (lost_d && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_q <= loss_cnt_q + 8'd1;
        end
    end

    assign lock_loss_cnt_o = loss_cnt_q;
`else
    assign lock_loss_cnt_o = '0;
`endif

    assign clken_o     = clken_q;
    assign sys_rst_o   = sys_rst_q;
    assign ready_o     = ~sys_rst_q;
    assign lock_lost_o = lost_q;

endmodule

// File: tb/tb_pll_clken_seq.sv
// Scoreboard bench for pll_clken_seq: a cycle reference model pushes expected
// outputs, a negedge monitor pops and compares them.
module tb_pll_clken_seq;

    localparam int unsigned NCH = 4;
    localparam int unsigned W   = 16;
    localparam int unsigned LF  = 255;
    localparam int unsigned RS  = 16;
    // Ticks from locked_i rising to ready_o: sync (2) + filter + stretch + state register.
    localparam int LOCK_TICKS = 2 + LF + RS + 1;
    localparam longint unsigned MOD = 64'd1 << W;
`ifdef PLL_CLKEN_LOSSCNT_EN
    localparam int NLOSS = 260;
`else
    localparam int NLOSS = 3;
`endif

    logic               refclk = 1'b0;
    logic               rst_n;
    logic               locked_i;
    logic [NCH*W-1:0]   inc_i;
    logic [NCH-1:0]     en_i;
    logic [NCH-1:0]     clken_o;
    logic               sys_rst_o;
    logic               ready_o;
    logic               lock_lost_o;
    logic [7:0]         lock_loss_cnt_o;

    always #5 refclk = ~refclk;

    pll_clken_seq #(
        .NUM_CH      (NCH),
        .ACC_W       (W),
        .LOCK_FILTER (LF),
        .RST_STRETCH (RS)
    ) dut (
        .refclk          (refclk),
        .rst_n           (rst_n),
        .locked_i        (locked_i),
        .inc_i           (inc_i),
        .en_i            (en_i),
        .clken_o         (clken_o),
        .sys_rst_o       (sys_rst_o),
        .ready_o         (ready_o),
        .lock_lost_o     (lock_lost_o),
        .lock_loss_cnt_o (lock_loss_cnt_o)
    );

    typedef struct packed {
        logic [NCH-1:0] clken;
        logic           sys_rst;
        logic           ready;
        logic           lost;
        logic [7:0]     cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state
    bit               m_l1, m_l2, m_ready, m_lost;
    int               m_run, m_cnt;
    longint unsigned  m_acc [NCH];
    bit [NCH-1:0]     m_clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // One clock edge of the reference model; ready is simply "lk has been high
    // for at least 1+LF+RS consecutive edges".
    task automatic model_step();
        bit lk, prev;
        longint unsigned s;
        exp_t e;
        if (!rst_n) begin
            m_l1 = 0; m_l2 = 0; m_run = 0; m_ready = 0; m_lost = 0; m_cnt = 0;
            m_clk = '0;
            for (int k = 0; k < int'(NCH); k++) m_acc[k] = 0;
        end else begin
            lk   = m_l2;
            prev = m_ready;
            for (int k = 0; k < int'(NCH); k++) begin
                if (prev && lk && en_i[k]) begin
                    s        = m_acc[k] + longint'(inc_i[k*W +: W]);
                    m_clk[k] = (s >= MOD);
                    m_acc[k] = s % MOD;
                end else begin
                    m_clk[k] = 0;
                    m_acc[k] = 0;
                end
            end
            m_lost = prev && !lk;
`ifdef PLL_CLKEN_LOSSCNT_EN
            if (m_lost && m_cnt < 255) m_cnt++;
`endif
            m_run   = lk ? ((m_run < 100000) ? m_run + 1 : m_run) : 0;
            m_ready = (m_run >= int'(1 + LF + RS));
            m_l2    = m_l1;
            m_l1    = locked_i;
        end
        e.clken   = m_clk;
        e.sys_rst = !m_ready;
        e.ready   = m_ready;
        e.lost    = m_lost;
        e.cnt     = 8'(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic tick();
        model_step();
        @(negedge refclk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready_o && n < 400) begin
            tick();
            n++;
        end
        if (!ready_o) check("ready_timeout", 32'(ready_o), 32'd1);
    endtask

    function automatic logic [W-1:0] pick_inc();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            default: return W'($urandom);
        endcase
    endfunction

    always @(negedge refclk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("sb_clken",   32'(clken_o),         32'(mon_e.clken));
            check("sb_sys_rst", 32'(sys_rst_o),       32'(mon_e.sys_rst));
            check("sb_ready",   32'(ready_o),         32'(mon_e.ready));
            check("sb_lost",    32'(lock_lost_o),     32'(mon_e.lost));
            check("sb_cnt",     32'(lock_loss_cnt_o), 32'(mon_e.cnt));
        end
    end

    initial begin
        int n, pulses, werr;
        int pc [NCH];
        logic [NCH-1:0] prev_clk;

        rst_n = 0; locked_i = 0; inc_i = '0; en_i = '0;
        tick(); tick();
        check("rst_sys_rst", 32'(sys_rst_o), 32'd1);
        check("rst_ready",   32'(ready_o), 32'd0);
        check("rst_clken",   32'(clken_o), 32'd0);
        rst_n = 1;
        repeat (5) tick();
        check("idle_ready", 32'(ready_o), 32'd0);

        // Lock-up timing
        inc_i[0*W +: W] = 16'h8000;
        inc_i[1*W +: W] = 16'h2AAB;
        inc_i[2*W +: W] = 16'h0000;
        inc_i[3*W +: W] = 16'hFFFF;
        en_i = '1;
        locked_i = 1;
        wait_ready(n);
        check("lockup_ticks", 32'(n), 32'(LOCK_TICKS));
        check("lockup_sys_rst", 32'(sys_rst_o), 32'd0);

        // Rate over the first 6000 adds in RUN
        for (int k = 0; k < int'(NCH); k++) pc[k] = 0;
        werr = 0;
        prev_clk = '0;
        for (int i = 0; i < 6000; i++) begin
            tick();
            for (int k = 0; k < int'(NCH); k++) if (clken_o[k]) pc[k]++;
            if ((clken_o[1:0] & prev_clk[1:0]) != 2'b00) werr++;
            prev_clk = clken_o;
        end
        check("rate_ch0", 32'(pc[0]), 32'd3000);
        check("rate_ch1", 32'(pc[1]), 32'd1000);
        check("rate_ch2", 32'(pc[2]), 32'd0);
        check("rate_ch3", 32'(pc[3]), 32'd5999);
        check("pulse_width", 32'(werr), 32'd0);

        // Lock loss, repeated
        for (int i = 0; i < NLOSS; i++) begin
            locked_i = 0;
            pulses = 0;
            repeat (6) begin
                tick();
                if (lock_lost_o) pulses++;
            end
            if (i < 3) begin
                check("loss_pulses",  32'(pulses), 32'd1);
                check("loss_sys_rst", 32'(sys_rst_o), 32'd1);
                check("loss_clken",   32'(clken_o), 32'd0);
            end
            locked_i = 1;
            wait_ready(n);
        end
`ifdef PLL_CLKEN_LOSSCNT_EN
        check("loss_cnt_sat", 32'(lock_loss_cnt_o), 32'd255);
`else
        check("loss_cnt_tied", 32'(lock_loss_cnt_o), 32'd0);
`endif

        // Glitch at filter count ~200 restarts the full filter
        locked_i = 0;
        repeat (4) tick();
        locked_i = 1;
        repeat (203) tick();
        locked_i = 0;
        tick();
        locked_i = 1;
        wait_ready(n);
        check("glitch_restart", 32'(n), 32'(LOCK_TICKS));

        // Enable dropped on a carry cycle suppresses the pulse
        inc_i[0*W +: W] = 16'h8000;
        en_i[0] = 1;
        repeat (3) tick();
        n = 0;
        while (m_acc[0] != 64'h8000 && n < 4) begin
            tick();
            n++;
        end
        en_i[0] = 0;
        tick();
        check("en_fall_carry", 32'(clken_o[0]), 32'd0);
        en_i[0] = 1;

        // Randomised traffic with occasional lock drops
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) en_i = NCH'($urandom);
            if ($urandom_range(0, 7) == 0) inc_i[$urandom_range(0, NCH-1)*W +: W] = pick_inc();
            locked_i = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        locked_i = 1;
        wait_ready(n);

        // Asynchronous reset in RUN
        repeat (10) tick();
        rst_n = 0;
        #1;
        check("midrun_rst_sys_rst", 32'(sys_rst_o), 32'd1);
        check("midrun_rst_ready",   32'(ready_o), 32'd0);
        check("midrun_rst_clken",   32'(clken_o), 32'd0);
        check("midrun_rst_lost",    32'(lock_lost_o), 32'd0);
        check("midrun_rst_cnt",     32'(lock_loss_cnt_o), 32'd0);
        repeat (3) tick();
        rst_n = 1;
        repeat (3) tick();
        check("post_rst_ready", 32'(ready_o), 32'd0);
        repeat (5) tick();

        @(negedge refclk);
        #1;
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pll_clken_seq.md
PLL_CLKEN_SEQ -- requirements
Module: pll_clken_seq

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 4, meaning number of clock-enable channels (legal range 1..8).
REQ-002 The module SHALL have parameter ACC_W, default 16, meaning phase-accumulator width per channel (legal range 8..32).
REQ-003 The module SHALL have parameter LOCK_FILTER, default 255, meaning consecutive synchronised-locked cycles required before sequencing starts (legal range 1..65535).
REQ-004 The module SHALL have parameter RST_STRETCH, default 16, meaning cycles that sys_rst_o is held after the lock filter passes (legal range 1..255).
REQ-005 The module SHALL have port refclk, input, 1 bit, meaning the single clock, driven by a PLL output.
REQ-006 The module SHALL have port rst_n, input, 1 bit, meaning reset, asynchronous and active-low.
REQ-007 The module SHALL have port locked_i, input, 1 bit, meaning PLL locked, asynchronous to refclk.
REQ-008 The module SHALL have port inc_i, input, NUM_CH*ACC_W bits, meaning per-channel increment, with channel k at bits [k*ACC_W +: ACC_W].
REQ-009 The module SHALL have port en_i, input, NUM_CH bits, meaning per-channel enable.
REQ-010 The module SHALL have port clken_o, output, NUM_CH bits, meaning per-channel single-cycle clock-enable pulses.
REQ-011 The module SHALL have port sys_rst_o, output, 1 bit, meaning active-high system reset for downstream logic.
REQ-012 The module SHALL have port ready_o, output, 1 bit, meaning the sequencer is in RUN.
REQ-013 The module SHALL have port lock_lost_o, output, 1 bit, meaning a one-cycle pulse on loss of lock while in RUN.
REQ-014 The module SHALL have port lock_loss_cnt_o, output, 8 bits, meaning the count of lock losses (see Configuration).

Function
REQ-015 locked_i SHALL pass through a 2-flop synchroniser; all decisions SHALL use the synchronised value (lk).
REQ-016 The FSM SHALL have exactly four states: WAIT_LOCK, FILTER, STRETCH and RUN.
REQ-017 WAIT_LOCK SHALL go to FILTER when lk=1, with the filter counter cleared.
REQ-018 FILTER SHALL increment its counter each cycle lk=1, SHALL return to WAIT_LOCK on any lk=0, and SHALL go to STRETCH when the counter reaches LOCK_FILTER-1 with lk=1.
REQ-019 STRETCH SHALL count RST_STRETCH cycles and then go to RUN; if lk=0 during STRETCH it SHALL go to WAIT_LOCK.
REQ-020 RUN SHALL go to WAIT_LOCK on lk=0, and lock_lost_o SHALL be 1 for exactly that transition cycle.
REQ-021 sys_rst_o SHALL be a registered output: 1 in every state except RUN, and 0 from the first RUN cycle; ready_o SHALL be its inverse.
REQ-022 Channel k accumulator update: in RUN with en_i[k]=1, {carry, acc_k} SHALL be acc_k + inc_k, computed ACC_W+1 bits wide.
REQ-023 clken_o[k] SHALL be the registered carry from REQ-022, i.e. one cycle of latency from the add.
REQ-024 Pulse rate SHALL be f_refclk*inc_k/2^ACC_W.
REQ-025 inc_k=0 SHALL produce no pulses.
REQ-026 inc_k=2^(ACC_W-1) SHALL produce a pulse every 2nd cycle.
REQ-027 inc_k=2^ACC_W-1 SHALL produce pulses on all cycles except one in every 2^ACC_W.
REQ-028 When en_i[k]=0 or the state is not RUN, acc_k SHALL clear to 0 and clken_o[k] SHALL be 0 on the next cycle.
REQ-029 If en_i[k] falls in the same cycle a carry would occur, that carry SHALL be suppressed.
REQ-030 A change of inc_k SHALL take effect on the next add without clearing acc_k.
REQ-031 On loss of lock in RUN, all accumulators SHALL clear and clken_o SHALL be 0 from the cycle after lk=0 is seen.

Reset
REQ-032 rst_n=0 SHALL asynchronously force state WAIT_LOCK, clear both synchroniser flops, counters and accumulators, and drive sys_rst_o=1, ready_o=0, clken_o=0, lock_lost_o=0 and lock_loss_cnt_o=0.
REQ-033 Release of rst_n SHALL be synchronous in effect: the first state change SHALL occur no earlier than 2 cycles after release.
REQ-034 Assertion of rst_n mid-RUN SHALL NOT pulse lock_lost_o and SHALL NOT increment lock_loss_cnt_o.

Configuration
REQ-035 With macro PLL_CLKEN_LOSSCNT_EN defined, lock_loss_cnt_o SHALL increment on each lock_lost_o pulse and saturate at 255, cleared only by rst_n.
REQ-036 With PLL_CLKEN_LOSSCNT_EN undefined, lock_loss_cnt_o SHALL be tied to 0, no counter logic SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-037 Lock-up scenario: LOCK_FILTER=255, RST_STRETCH=16, locked_i rising at cycle 0 -> sys_rst_o falls at cycle 2+255+16 (+/-1 for registration) and ready_o=1 thereafter.
REQ-038 Glitch-filter scenario: locked_i low for 1 cycle at filter count 200 -> state returns to WAIT_LOCK and the full 255-cycle filter restarts.
REQ-039 Rate scenario: ACC_W=16, ch0 inc=0x8000, ch1 inc=0x2AAB, ch2 inc=0 over 6000 RUN cycles -> 3000, 1000 and 0 pulses respectively; every pulse is exactly one cycle wide.
REQ-040 Lock-loss scenario: locked_i dropped in RUN -> lock_lost_o pulses once, sys_rst_o returns to 1, clken_o goes to 0 and, with the macro defined, lock_loss_cnt_o goes 0->1; 300 losses -> lock_loss_cnt_o=255.
REQ-041 Enable/reset scenario: en_i[0] deasserted on a carry cycle -> no pulse is produced; rst_n asserted mid-RUN -> all outputs take their reset values immediately and lock_lost_o stays 0.
